// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
//   Shared types and constants for the PLL lock supervisor:
//     sup_state_t  - sequencer states
//     lf_cfg_t     - one dynamic loop-filter setting {icpsel, lpfres, lpfcap}
//     lf_lookup()  - the constant 4-entry loop-filter table, tried in order
//     max3()       - helper used to size the shared state counter
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        LOCKED,
        FAULT
    } sup_state_t;

    typedef struct packed {
        logic [5:0] icpsel;
        logic [2:0] lpfres;
        logic [1:0] lpfcap;
    } lf_cfg_t;

    localparam int LF_TABLE_DEPTH = 4;

    // Entry 0 is the nominal setting; later entries are progressively
    // different bandwidth choices tried when lock is not achieved.
    function automatic lf_cfg_t lf_lookup(input logic [1:0] idx);
        lf_cfg_t cfg;
        case (idx)
            2'd0:    cfg = '{icpsel: 6'd16, lpfres: 3'd2, lpfcap: 2'd0};
            2'd1:    cfg = '{icpsel: 6'd24, lpfres: 3'd3, lpfcap: 2'd0};
            2'd2:    cfg = '{icpsel: 6'd12, lpfres: 3'd1, lpfcap: 2'd1};
            default: cfg = '{icpsel: 6'd32, lpfres: 3'd4, lpfcap: 2'd1};
        endcase
        return cfg;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// pll_sup_sync2
//   Two-flop synchroniser bringing the PLL lock indication into the clkin
//   domain. Both flops clear on reset so a stale lock cannot leak through
//   after the supervisor is reset.
//   Ports:
//     clkin  in   reference clock
//     reset  in   synchronous, active-high reset
//     din    in   asynchronous input
//     dout   out  synchronised output, two cycles behind din
module pll_sup_sync2 (
    input  logic clkin,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clkin) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= din;
            // second stage: metastability settling
            sync_p1 <= sync_p0;
        end
    end

    assign dout = sync_p1;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences the Ethernet clock PLL: pulses its reset, applies a loop-filter
//   setting, waits for lock, debounces it and then raises clk_ok. A lock
//   timeout moves to the next loop-filter setting; losing lock re-runs the
//   reset with the same setting; running out of settings latches fault.
//
//   Optional build macro: PLL_SUP_RELOCK_CNT_EN adds relock_cnt, a saturating
//   count of LOCKED -> RST_PLL transitions, cleared by reset and restart.
//
//   Ports:
//     clkin       in   50 MHz reference clock, the only clock
//     reset       in   synchronous, active-high reset (wins over restart)
//     restart     in   pulse: restart from table entry 0, clears fault
//     pll_lock    in   PLL lock output, asynchronous
//     pll_reset   out  PLL reset, active-high
//     icpsel      out  charge-pump select for the current entry
//     lpfres      out  loop-filter resistor for the current entry
//     lpfcap      out  loop-filter capacitor for the current entry
//     clk_ok      out  PLL locked and stable
//     fault       out  every table entry failed to lock
//     cfg_idx     out  table entry currently applied
//     relock_cnt  out  (PLL_SUP_RELOCK_CNT_EN only) lock-loss counter
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 100,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int NUM_CFG       = 4
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] icpsel,
    output logic [2:0] lpfres,
    output logic [1:0] lpfcap,
    output logic       clk_ok,
    output logic       fault,
    output logic [1:0] cfg_idx
`ifdef PLL_SUP_RELOCK_CNT_EN
    ,
    output logic [7:0] relock_cnt
`endif
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    // The counter holds cycles already spent in the current state and is
    // cleared on every state entry, so a state lasts LIMIT cycles when it
    // leaves on the cycle the count reaches LIMIT-1.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       LAST_IDX    = 2'(NUM_CFG - 1);

    sup_state_t       state;
    logic [CNT_W-1:0] cnt;
    lf_cfg_t          lf_cfg;
    logic             lock_s;

    pll_sup_sync2 u_sync (
        .clkin (clkin),
        .reset (reset),
        .din   (pll_lock),
        .dout  (lock_s)
    );

    // Sequencer. restart has the same effect on the sequencer as reset; the
    // only differences are the synchroniser (reset only) and priority.
    // The loop-filter register is loaded together with cfg_idx so the two
    // never disagree, and cfg_idx only moves on entry to RST_PLL while
    // pll_reset is held high.
    always_ff @(posedge clkin) begin
        if (reset || restart) begin
            state     <= RST_PLL;
            cnt       <= '0;
            cfg_idx   <= 2'd0;
            lf_cfg    <= lf_lookup(2'd0);
            pll_reset <= 1'b1;
            clk_ok    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                RST_PLL: begin
                    if (cnt == RST_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    // lock seen in the expiry cycle still counts as a lock
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        if (cfg_idx < LAST_IDX) begin
                            state   <= RST_PLL;
                            cfg_idx <= cfg_idx + 2'd1;
                            lf_cfg  <= lf_lookup(cfg_idx + 2'd1);
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STABLE: begin
                    if (!lock_s) begin
                        state     <= RST_PLL;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                    end else if (cnt == STABLE_LAST) begin
                        state  <= LOCKED;
                        cnt    <= '0;
                        clk_ok <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LOCKED: begin
                    // clk_ok falls on the same edge pll_reset rises
                    if (!lock_s) begin
                        state     <= RST_PLL;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        clk_ok    <= 1'b0;
                    end
                end

                FAULT: begin
                    // parked with pll_reset high until restart or reset
                    pll_reset <= 1'b1;
                    clk_ok    <= 1'b0;
                    fault     <= 1'b1;
                end

                default: begin
                    state     <= RST_PLL;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    clk_ok    <= 1'b0;
                end
            endcase
        end
    end

    assign icpsel = lf_cfg.icpsel;
    assign lpfres = lf_cfg.lpfres;
    assign lpfcap = lf_cfg.lpfcap;

`ifdef PLL_SUP_RELOCK_CNT_EN
    // Counts lock losses out of LOCKED; restart clears it, so a restart
    // issued while LOCKED is not counted as a relock.
    always_ff @(posedge clkin) begin
        if (reset || restart) begin
            relock_cnt <= 8'd0;
        end else if (state == LOCKED && !lock_s && relock_cnt != 8'hFF) begin
            relock_cnt <= relock_cnt + 8'd1;
        end
    end
`else
    // No relock counter in this build.
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Drives directed scenarios followed by randomized lock/restart/reset
//   activity. Each driven cycle is run through a behavioural reference model
//   and the predicted outputs are queued; an independent monitor pops one
//   prediction per clock and compares it with the DUT outputs.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int NUM_CFG       = 4;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
    logic       clk_ok;
    logic       fault;
    logic [1:0] cfg_idx;
`ifdef PLL_SUP_RELOCK_CNT_EN
    logic [7:0] relock_cnt;
`endif

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .NUM_CFG       (NUM_CFG)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .restart   (restart),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .icpsel    (icpsel),
        .lpfres    (lpfres),
        .lpfcap    (lpfcap),
        .clk_ok    (clk_ok),
        .fault     (fault),
        .cfg_idx   (cfg_idx)
`ifdef PLL_SUP_RELOCK_CNT_EN
        ,
        .relock_cnt(relock_cnt)
`endif
    );

    always #5 clkin = ~clkin;

    typedef struct packed {
        logic       pll_reset;
        logic       clk_ok;
        logic       fault;
        logic [1:0] idx;
        logic [5:0] icp;
        logic [2:0] res;
        logic [1:0] cap;
        logic [7:0] relock;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Loop-filter table as the datasheet lists it.
    int ICP_TAB[4] = '{16, 24, 12, 32};
    int RES_TAB[4] = '{2, 3, 1, 4};
    int CAP_TAB[4] = '{0, 0, 1, 1};

    // Reference model: phase of the sequence plus cycles remaining in it.
    localparam int P_RST = 0, P_WAIT = 1, P_QUAL = 2, P_LOCKED = 3, P_FAULT = 4;
    int   m_phase  = P_RST;
    int   m_left   = RST_CYCLES;
    int   m_idx    = 0;
    int   m_relock = 0;
    logic m_hist[2] = '{1'b0, 1'b0};  // [0] newest sample, [1] visible to sequencer

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic model_step(input logic r, input logic rs, input logic lk);
        logic seen;
        exp_t e;
        if (r) begin
            m_phase = P_RST; m_left = RST_CYCLES; m_idx = 0; m_relock = 0;
            m_hist[0] = 1'b0; m_hist[1] = 1'b0;
        end else begin
            seen = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = lk;
            if (rs) begin
                m_phase = P_RST; m_left = RST_CYCLES; m_idx = 0; m_relock = 0;
            end else begin
                case (m_phase)
                    P_RST: begin
                        m_left--;
                        if (m_left == 0) begin m_phase = P_WAIT; m_left = LOCK_TIMEOUT; end
                    end
                    P_WAIT: begin
                        if (seen) begin
                            m_phase = P_QUAL; m_left = STABLE_CYCLES;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin
                                if (m_idx < NUM_CFG - 1) begin
                                    m_idx++; m_phase = P_RST; m_left = RST_CYCLES;
                                end else begin
                                    m_phase = P_FAULT;
                                end
                            end
                        end
                    end
                    P_QUAL: begin
                        if (!seen) begin
                            m_phase = P_RST; m_left = RST_CYCLES;
                        end else begin
                            m_left--;
                            if (m_left == 0) m_phase = P_LOCKED;
                        end
                    end
                    P_LOCKED: begin
                        if (!seen) begin
                            m_phase = P_RST; m_left = RST_CYCLES;
                            if (m_relock < 255) m_relock++;
                        end
                    end
                    default: ;
                endcase
            end
        end
        e.pll_reset = (m_phase == P_RST) || (m_phase == P_FAULT);
        e.clk_ok    = (m_phase == P_LOCKED);
        e.fault     = (m_phase == P_FAULT);
        e.idx       = 2'(m_idx);
        e.icp       = 6'(ICP_TAB[m_idx]);
        e.res       = 3'(RES_TAB[m_idx]);
        e.cap       = 2'(CAP_TAB[m_idx]);
        e.relock    = 8'(m_relock);
        exp_q.push_back(e);
    endtask

    // Drive one clock of inputs, predict, then wait for the next falling edge.
    task automatic step(input logic r, input logic rs, input logic lk);
        reset = r; restart = rs; pll_lock = lk;
        model_step(r, rs, lk);
        @(negedge clkin);
    endtask

    task automatic hold(input int n, input logic r, input logic rs, input logic lk);
        for (int i = 0; i < n; i++) step(r, rs, lk);
    endtask

    // Monitor: one prediction per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clkin);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pll_reset", int'(pll_reset), int'(e.pll_reset));
                check("clk_ok",    int'(clk_ok),    int'(e.clk_ok));
                check("fault",     int'(fault),     int'(e.fault));
                check("cfg_idx",   int'(cfg_idx),   int'(e.idx));
                check("icpsel",    int'(icpsel),    int'(e.icp));
                check("lpfres",    int'(lpfres),    int'(e.res));
                check("lpfcap",    int'(lpfcap),    int'(e.cap));
                check("clk_ok_with_pll_reset", int'(clk_ok & pll_reset), 0);
`ifdef PLL_SUP_RELOCK_CNT_EN
                check("relock_cnt", int'(relock_cnt), int'(e.relock));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lk_cur;
        int   run;
        logic r, rs;

        // reset state
        hold(3, 1'b1, 1'b0, 1'b0);
        // nominal lock: lock rises 5 cycles after pll_reset falls
        hold(9, 1'b0, 1'b0, 1'b0);
        hold(30, 1'b0, 1'b0, 1'b1);
        // lock loss while LOCKED, relock on the same entry
        hold(1, 1'b0, 1'b0, 1'b0);
        hold(30, 1'b0, 1'b0, 1'b1);
        // glitch while qualifying
        hold(10, 1'b0, 1'b0, 1'b0);
        hold(5, 1'b0, 1'b0, 1'b1);
        hold(1, 1'b0, 1'b0, 1'b0);
        hold(30, 1'b0, 1'b0, 1'b1);
        // timeout stepping through every entry into FAULT, then hold
        hold(120, 1'b0, 1'b0, 1'b0);
        // restart from FAULT
        hold(1, 1'b0, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b0, 1'b0);
        // restart during the reset pulse extends it
        hold(1, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b0, 1'b0);
        hold(1, 1'b0, 1'b1, 1'b0);
        hold(8, 1'b0, 1'b0, 1'b0);
        // reset and restart together
        hold(1, 1'b1, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b0, 1'b0);
        // reset while qualifying, lock still high
        hold(5, 1'b0, 1'b0, 1'b1);
        hold(1, 1'b1, 1'b0, 1'b1);
        hold(20, 1'b0, 1'b0, 1'b1);

        // randomized lock runs with occasional restart/reset
        lk_cur = 1'b0;
        run    = 0;
        for (int c = 0; c < 2500; c++) begin
            if (run == 0) begin
                lk_cur = ~lk_cur;
                run = lk_cur ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
            end
            run--;
            rs = ($urandom_range(0, 199) == 0);
            r  = ($urandom_range(0, 599) == 0);
            step(r, rs, lk_cur);
        end
        hold(5, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clkin);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
